// File: rtl/nib_track_writeback.sv
// Writes a dirty 6656-byte NIB track buffer back to the SD image, one 512-byte sector per hps_io handshake.
// Optional macro NIB_WB_SECTOR_MASK_EN: per-sector dirty mask so only modified sectors are written.
module nib_track_writeback #(
  parameter int SECS_PER_TRACK = 13,
  parameter int TRACK_W = 6
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [TRACK_W-1:0] track,
  input  logic               dirty_set,
  input  logic [12:0]        dirty_addr,
  input  logic               flush,
  input  logic               img_mounted,
  input  logic [63:0]        img_size,
  input  logic               img_readonly,
  output logic [31:0]        sd_lba,
  output logic               sd_wr,
  input  logic               sd_ack,
  input  logic [8:0]         sd_buff_addr,
  output logic [7:0]         sd_buff_din,
  output logic [12:0]        tram_addr,
  input  logic [7:0]         tram_dout,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, NEXT} state_t;

  state_t                    state;
  logic [3:0]                sec;
  logic [TRACK_W-1:0]        cur_track;
  logic [SECS_PER_TRACK-1:0] mask;
  logic [SECS_PER_TRACK-1:0] re_mask;
  logic [SECS_PER_TRACK-1:0] mark;
  logic                      old_ack;
  logic                      abort;
  logic                      dirty;
  logic                      writable;
  logic                      ack_rise;
  logic                      ack_fall;
  logic [31:0]               lba_base;
  logic [4:0]                scan_from;
  logic                      scan_hit;
  logic [3:0]                scan_idx;

  assign tram_addr   = {sec, sd_buff_addr};
  assign sd_buff_din = tram_dout;
  assign dirty       = |mask;
  assign writable    = !img_readonly && (img_size != 64'd0);
  assign ack_rise    = sd_ack && !old_ack;
  assign ack_fall    = !sd_ack && old_ack;
  assign lba_base    = 32'(cur_track) * 32'(SECS_PER_TRACK);

`ifdef NIB_WB_SECTOR_MASK_EN
  always_comb begin
    mark = '0;
    if (dirty_addr[12:9] < 4'(SECS_PER_TRACK))
      mark[dirty_addr[12:9]] = 1'b1;
  end
`else
  // Without per-sector tracking any write dirties the whole track.
  assign mark = '1;
  logic unused_addr;
  assign unused_addr = ^dirty_addr;
`endif

  // Lowest dirty sector at or above scan_from; a miss in NEXT means the track is finished.
  always_comb begin
    scan_from = (state == IDLE) ? 5'd0 : 5'(sec) + 5'd1;
    scan_hit  = 1'b0;
    scan_idx  = '0;
    for (int i = SECS_PER_TRACK - 1; i >= 0; i--) begin
      if (mask[i] && (5'(i) >= scan_from)) begin
        scan_hit = 1'b1;
        scan_idx = 4'(i);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      sd_wr     <= 1'b0;
      sd_lba    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mask      <= '0;
      re_mask   <= '0;
      sec       <= '0;
      cur_track <= track;
      old_ack   <= 1'b0;
      abort     <= 1'b0;
    end else begin
      old_ack <= sd_ack;
      done    <= 1'b0;
      if (state != IDLE) begin
        if (img_mounted) abort <= 1'b1;
        if (dirty_set && writable) re_mask <= re_mask | mark;
      end
      case (state)
        IDLE: begin
          if (img_mounted) begin
            mask      <= '0;
            cur_track <= track;
          end else if (dirty && (flush || (track != cur_track))) begin
            if (img_readonly) begin
              mask <= '0;
              done <= 1'b1;
            end else begin
              busy    <= 1'b1;
              sec     <= scan_idx;
              sd_lba  <= lba_base + 32'(scan_idx);
              sd_wr   <= 1'b1;
              abort   <= 1'b0;
              re_mask <= (dirty_set && writable) ? mark : '0;
              state   <= REQ;
            end
          end else begin
            if (flush) done <= 1'b1;
            if (!dirty) cur_track <= track;
            if (dirty_set && writable) mask <= mask | mark;
          end
        end
        REQ: begin
          if (ack_rise) begin
            sd_wr <= 1'b0;
            state <= XFER;
          end
        end
        XFER: begin
          if (ack_fall) state <= NEXT;
        end
        NEXT: begin
          if (abort || img_mounted) begin
            busy    <= 1'b0;
            mask    <= '0;
            re_mask <= '0;
            state   <= IDLE;
          end else if (scan_hit) begin
            sec    <= scan_idx;
            sd_lba <= lba_base + 32'(scan_idx);
            sd_wr  <= 1'b1;
            state  <= REQ;
          end else begin
            // Writes that slipped in while busy keep the track dirty for another pass.
            mask      <= re_mask;
            re_mask   <= '0;
            cur_track <= track;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nib_track_writeback.md
Name: nib_track_writeback

Overview:
- Writer counterpart of the NIB track loader: flushes a modified 6656-byte track buffer (13 × 512-byte SD sectors) back to the mounted disk image through the hps_io SD write path.
- Sits between the Disk II track RAM second read port and hps_io (sd_wr/sd_ack/sd_buff_*).
- Asserts busy so the track loader and CPU_WAIT hold off until the old track is on the image.

Parameters:
SECS_PER_TRACK, 13, SD sectors per NIB track (6656/512)
TRACK_W, 6, track number width

Ports:
clk_sys       in   1        system clock (14 MHz domain)
reset         in   1        synchronous, active-high reset
track         in   TRACK_W  track currently selected by the drive head
dirty_set     in   1        one-cycle pulse: CPU wrote the track RAM
dirty_addr    in   13       track RAM byte address of that write
flush         in   1        one-cycle pulse: write back now if dirty (OSD/unmount)
img_mounted   in   1        pulse: new image mounted
img_size      in   64       image size; 0 = no image
img_readonly  in   1        image is write-protected
sd_lba        out  32       LBA of the sector being written
sd_wr         out  1        write request to hps_io
sd_ack        in   1        hps_io transfer acknowledge
sd_buff_addr  in   9        byte index within the sector, driven by hps_io
sd_buff_din   out  8        byte to hps_io
tram_addr     out  13       track RAM read address
tram_dout     in   8        track RAM read data, 1-cycle registered latency
busy          out  1        writeback in progress
done          out  1        one-cycle pulse when a writeback completes

Behaviour:
- Reset values: sd_wr=0, sd_lba=0, busy=0, done=0, dirty=0, sec=0, cur_track=track, state=IDLE.
- cur_track latches the track whose data occupies the buffer. It follows track whenever not dirty and IDLE.
- Datapath:
  - tram_addr = {sec[3:0], sd_buff_addr}, combinational.
  - sd_buff_din = tram_dout, passed through.
  - The 1-cycle RAM latency matches hps_io's write-sampling timing.
- dirty sets on dirty_set, ignored while img_readonly=1 or img_size=0.
- Triggers, evaluated in IDLE only:
  - (track != cur_track && dirty), or (flush && dirty): start writeback of cur_track.
  - flush with dirty=0: no SD traffic, but done pulses.
- FSM states IDLE, REQ, XFER, NEXT.
  - IDLE -> REQ on trigger: busy=1, sec=0, sd_lba = 13*cur_track.
  - REQ: sd_wr=1. On the sd_ack rising edge, sd_wr<=0 and go to XFER.
  - XFER: on the sd_ack falling edge, go to NEXT.
  - NEXT: if sec==SECS_PER_TRACK-1, then dirty<=0, cur_track<=track, busy<=0, done=1 for one cycle, go to IDLE. Otherwise sec+1, sd_lba+1, go to REQ.
- Edge detection uses a registered old_ack, so there is one cycle of edge-detect latency.
- LBA arithmetic: 13*track is computed at 32 bits. Max track 34 gives 442, last LBA 454.
- dirty_set during busy: the CPU is held, so this is not expected. If it occurs, a re_dirty flag is set and dirty remains 1 after completion.
- img_mounted:
  - In IDLE: dirty<=0, cur_track<=track. The old image's data is discarded.
  - In REQ/XFER/NEXT: abort after the current ack falls. Do not issue further sectors; busy drops, done is not pulsed, dirty<=0.
- img_readonly=1 at a trigger: no write; dirty<=0; done pulses.
- Reset mid-writeback: return to reset values immediately and drop sd_wr. Partial image content is accepted.
- Track change during busy is ignored until IDLE, then re-evaluated.

Optional Feature:
- Macro: NIB_WB_SECTOR_MASK_EN
- Defined:
  - A 13-bit mask replaces the single dirty bit; mask[dirty_addr[12:9]] is set on dirty_set, and dirty = |mask.
  - In IDLE->REQ and NEXT, sec advances to the next set mask bit; clean sectors are skipped with no sd_wr.
  - sd_lba = 13*cur_track + sec.
  - Completion occurs after the highest set bit, and the mask clears.
- Undefined: all 13 sectors are written on every writeback.

Test Plan:
- Reset, mount a 232960-byte image, track=5, dirty_set at addr 0x0100, then track=6 -> 13 sd_wr handshakes with sd_lba 65..77, bytes taken from tram[sec*512+i], busy high throughout, one done pulse, cur_track=6, dirty=0.
- track 5->6 with no dirty_set -> no sd_wr, busy stays 0, cur_track=6.
- dirty_set with img_readonly=1, then flush -> no sd_wr, done pulse, dirty=0.
- img_mounted asserted during the 4th sector's XFER -> 4th handshake completes, no 5th sd_wr, busy falls, no done.
- Reset asserted in REQ of sector 7 -> sd_wr=0 the next cycle, busy=0, state IDLE.
- NIB_WB_SECTOR_MASK_EN defined, track 34, dirty_addr 0x0000 and 0x19FF, flush -> exactly two writes at LBA 442 and 454, then done.
